// File: rtl/axis_pfb_4x64.sv
// axis_pfb_4x64: 2-tap polyphase front end, 4 samples in / 8 lanes out.
// AXI-Lite slave holds the output quantization shift (QOUT).
module axis_pfb_4x64 #(
  parameter int L = 4,
  parameter int N = 64
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [5:0]       s_axi_awaddr,
  input  logic [2:0]       s_axi_awprot,
  input  logic             s_axi_awvalid,
  output logic             s_axi_awready,
  input  logic [31:0]      s_axi_wdata,
  input  logic [3:0]       s_axi_wstrb,
  input  logic             s_axi_wvalid,
  output logic             s_axi_wready,
  output logic [1:0]       s_axi_bresp,
  output logic             s_axi_bvalid,
  input  logic             s_axi_bready,
  input  logic [5:0]       s_axi_araddr,
  input  logic [2:0]       s_axi_arprot,
  input  logic             s_axi_arvalid,
  output logic             s_axi_arready,
  output logic [31:0]      s_axi_rdata,
  output logic [1:0]       s_axi_rresp,
  output logic             s_axi_rvalid,
  input  logic             s_axi_rready,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [32*L-1:0]  s_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic [64*L-1:0]  m_axis_tdata
);

  localparam int H  = 2 * N;
  localparam int OL = 2 * L;

  logic [31:0]     hist_q [H];
  logic [31:0]     frame_d [N];
  logic [31:0]     frame_q [N];
  logic [2:0]      cnt_q, cnt_d;
  logic            fire_q;
  logic [4:0]      qsel_q;
  logic            busy_q;
  logic [2:0]      ob_q;
  logic            tvalid_q, tlast_q;
  logic [64*L-1:0] tdata_q, beat_d;
  logic            tready_q;
  logic            awready_q, bvalid_q;
  logic            arready_q, rvalid_q;
  logic [31:0]     rdata_q;
  logic [4:0]      qout_q;
  logic            acc, done;

  assign acc   = s_axis_tvalid && tready_q;
  assign done  = acc && (cnt_q == 3'd7);
  assign cnt_d = cnt_q + 3'd1;

  // Sum two samples, floor-shift by q (capped at 16), saturate to 16 bits.
  function automatic logic [15:0] quant(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic [4:0]  q
  );
    logic signed [16:0] s;
    logic signed [16:0] t;
    logic [4:0]         sh;
    s  = $signed({a[15], a}) + $signed({b[15], b});
    sh = (q > 5'd16) ? 5'd16 : q;
    t  = s >>> sh;
    if (t > 17'sd32767)
      return 16'h7fff;
    else if (t < -17'sd32768)
      return 16'h8000;
    else
      return t[15:0];
  endfunction

  // Sample history: shift in one beat, oldest lane lands lowest.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int k = 0; k < H; k++)
        hist_q[k] <= '0;
    end else if (acc) begin
      for (int k = 0; k < H - L; k++)
        hist_q[k] <= hist_q[k+L];
      for (int k = 0; k < L; k++)
        hist_q[H-L+k] <= s_axis_tdata[32*k +: 32];
    end
  end

  // Beat counter and completion pulse with the QOUT snapshot.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q    <= '0;
      fire_q   <= 1'b0;
      qsel_q   <= '0;
      tready_q <= 1'b1;
    end else begin
      tready_q <= 1'b1;
      fire_q   <= done;
      if (acc)
        cnt_q <= cnt_d;
      if (done)
        qsel_q <= qout_q;
    end
  end

  // Two-tap polyphase sums over the settled history.
  always_comb begin
    for (int n = 0; n < N; n++)
      frame_d[n] = {quant(hist_q[n][31:16], hist_q[n+N][31:16], qsel_q),
                    quant(hist_q[n][15:0],  hist_q[n+N][15:0],  qsel_q)};
  end

  // Frame buffer captured one cycle after completion.
  always_ff @(posedge aclk) begin
    if (fire_q)
      for (int n = 0; n < N; n++)
        frame_q[n] <= frame_d[n];
  end

  // Select the eight lanes of the current output beat.
  always_comb begin
    beat_d = '0;
    for (int i = 0; i < OL; i++)
      beat_d[32*i +: 32] = frame_q[{ob_q, i[2:0]}];
  end

  // Output sequencer: eight beats per frame, a new frame may chain on.
  always_ff @(posedge aclk) begin
    if (areset) begin
      busy_q   <= 1'b0;
      ob_q     <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= busy_q;
      tlast_q  <= busy_q && (ob_q == 3'd7);
      if (busy_q) begin
        tdata_q <= beat_d;
        ob_q    <= ob_q + 3'd1;
        if (ob_q == 3'd7)
          busy_q <= 1'b0;
      end
      if (fire_q) begin
        busy_q <= 1'b1;
        ob_q   <= '0;
      end
    end
  end

  // AXI-Lite write and read channels around the QOUT register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      qout_q    <= '0;
    end else begin
      awready_q <= 1'b0;
      if (!awready_q && !bvalid_q && s_axi_awvalid && s_axi_wvalid)
        awready_q <= 1'b1;
      if (awready_q) begin
        bvalid_q <= 1'b1;
        if (s_axi_awaddr[5:2] == 4'd0 && s_axi_wstrb[0])
          qout_q <= s_axi_wdata[4:0];
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= 1'b0;
      if (!arready_q && !rvalid_q && s_axi_arvalid)
        arready_q <= 1'b1;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= (s_axi_araddr[5:2] == 4'd0) ? {27'd0, qout_q} : 32'd0;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                       s_axi_araddr[1:0], s_axi_wdata[31:5],
                       s_axi_wstrb[3:1]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_axis_pfb_4x64.sv
// tb_axis_pfb_4x64: vector table plus scoreboard bench
// for the polyphase front end.
module tb_axis_pfb_4x64;

  logic         clk;
  logic         areset;
  logic [5:0]   s_axi_awaddr;
  logic [2:0]   s_axi_awprot;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [5:0]   s_axi_araddr;
  logic [2:0]   s_axi_arprot;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic [255:0] m_axis_tdata;

  axis_pfb_4x64 dut (
    .aclk(clk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [4:0]  qo;
    logic [15:0] ei;
    logic [15:0] eq;
  } vec_t;

  typedef struct {
    logic [255:0] d;
    logic         l;
  } ex_t;

  int           total;
  int           bad;
  int           cyc;
  bit           mon_on;
  bit           prev_v;
  ex_t          expq[$];
  logic [255:0] cap[$];
  int           rises[$];
  int           lasts[$];
  logic [31:0]  hist_m[128];
  int           cnt_m;
  int           qout_m;
  vec_t         tbl[5];

  task automatic chk(input string nm, input logic [255:0] a,
                     input logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  function automatic logic [15:0] qz(input logic [15:0] a,
                                     input logic [15:0] b);
    int s;
    int sh;
    s  = $signed(a);
    s  = s + $signed(b);
    sh = (qout_m > 16) ? 16 : qout_m;
    s  = s >>> sh;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic push_frame();
    ex_t e;
    int  n;
    for (int j = 0; j < 8; j++) begin
      e.d = '0;
      e.l = (j == 7);
      for (int i = 0; i < 8; i++) begin
        n = 8 * j + i;
        e.d[32*i +: 32] = {qz(hist_m[n][31:16], hist_m[n+64][31:16]),
                           qz(hist_m[n][15:0], hist_m[n+64][15:0])};
      end
      expq.push_back(e);
    end
  endtask

  task automatic model_beat(input logic [127:0] d);
    for (int k = 0; k < 124; k++) hist_m[k] = hist_m[k+4];
    for (int k = 0; k < 4; k++) hist_m[124+k] = d[32*k +: 32];
    cnt_m++;
    if (cnt_m == 8) begin
      cnt_m = 0;
      push_frame();
    end
  endtask

  task automatic send_beat(input logic [127:0] d);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    model_beat(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    areset = 1'b1;
    idle(3);
    areset = 1'b0;
    for (int k = 0; k < 128; k++) hist_m[k] = '0;
    cnt_m  = 0;
    qout_m = 0;
    expq.delete();
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (expq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1'b1);
    idle(3);
  endtask

  task automatic axi_wr(input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] st);
    bit ok;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = st;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi_awready && s_axi_wready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("wr_handshake", ok, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wr_bvalid", ok, 1'b1);
    chk("wr_bresp", s_axi_bresp, 2'b00);
    @(posedge clk);
    #1;
    if (a[5:2] == 4'd0 && st[0]) qout_m = int'(d[4:0]);
  endtask

  task automatic axi_rd(input logic [5:0] a, output logic [31:0] d);
    bit ok;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    d  = 'x;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    chk("rd_handshake", ok, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin
        ok = 1'b1;
        d  = s_axi_rdata;
        break;
      end
    end
    chk("rd_rvalid", ok, 1'b1);
    chk("rd_rresp", s_axi_rresp, 2'b00);
    @(posedge clk);
    #1;
  endtask

  task automatic mon_loop();
    ex_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_on) begin
        if (m_axis_tvalid) begin
          if (!prev_v) rises.push_back(cyc);
          if (m_axis_tlast) lasts.push_back(cyc);
          cap.push_back(m_axis_tdata);
          if (expq.size() == 0) begin
            chk("unexpected_beat", m_axis_tvalid, 1'b0);
          end else begin
            e = expq.pop_front();
            chk("beat_data", m_axis_tdata, e.d);
            chk("beat_last", m_axis_tlast, e.l);
          end
        end else begin
          chk("tlast_idle", m_axis_tlast, 1'b0);
        end
        prev_v = m_axis_tvalid;
      end
    end
  endtask

  task automatic run_all();
    logic [31:0]  rd;
    logic [127:0] d;
    logic [255:0] e;
    logic [31:0]  w;

    tbl[0] = '{16'sd1000, -16'sd1000, 5'd0, 16'sd2000, -16'sd2000};
    tbl[1] = '{16'sd1000, -16'sd1000, 5'd4, 16'sd125, -16'sd125};
    tbl[2] = '{16'sd30000, 16'sd0, 5'd0, 16'sd32767, 16'sd0};
    tbl[3] = '{-16'sd30000, 16'sd0, 5'd0, 16'h8000, 16'sd0};
    tbl[4] = '{16'sd1000, -16'sd1000, 5'd31, 16'sd0, 16'hffff};

    reset_dut();
    mon_on = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tready", s_axis_tready, 1'b1);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    idle(1);
    axi_rd(6'h00, rd);
    chk("rst_qout", rd, 32'd0);

    // register map
    axi_wr(6'h00, 32'd4, 4'hf);
    axi_rd(6'h00, rd);
    chk("qout_4", rd, 32'd4);
    axi_wr(6'h04, 32'd7, 4'hf);
    axi_rd(6'h04, rd);
    chk("addr4_zero", rd, 32'd0);
    axi_rd(6'h00, rd);
    chk("qout_kept", rd, 32'd4);
    axi_wr(6'h00, 32'd31, 4'hf);
    axi_rd(6'h00, rd);
    chk("qout_31", rd, 32'd31);
    axi_wr(6'h00, 32'd9, 4'h0);
    axi_rd(6'h00, rd);
    chk("qout_nostrb", rd, 32'd31);

    // constant-input table, five back-to-back frames per row
    for (int r = 0; r < 5; r++) begin
      axi_wr(6'h00, {27'd0, tbl[r].qo}, 4'h1);
      rises.delete();
      lasts.delete();
      cap.delete();
      d = {4{tbl[r].q, tbl[r].i}};
      for (int b = 0; b < 40; b++) send_beat(d);
      drain();
      e = {8{tbl[r].eq, tbl[r].ei}};
      chk($sformatf("settled_row%0d", r), cap[cap.size()-1], e);
      chk("contig_bursts", rises.size(), 1);
      chk("tlast_count", lasts.size(), 5);
    end

    // ramp: first-frame latency and lane placement
    reset_dut();
    cap.delete();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 4; i++) d[32*i +: 32] = {16'd0, 16'(4*b+i)};
      send_beat(d);
    end
    @(negedge clk);
    chk("lat_cyc0", m_axis_tvalid, 1'b0);
    @(negedge clk);
    chk("lat_cyc1", m_axis_tvalid, 1'b0);
    @(negedge clk);
    chk("lat_cyc2", m_axis_tvalid, 1'b1);
    drain();
    chk("ramp_beats", cap.size(), 8);
    if (cap.size() == 8) begin
      chk("ramp_b0_3", cap[0] | cap[1] | cap[2] | cap[3], '0);
      for (int i = 0; i < 8; i++) e[32*i +: 32] = {16'd0, 16'(i)};
      chk("ramp_b4", cap[4], e);
      for (int i = 0; i < 8; i++) e[32*i +: 32] = {16'd0, 16'(24+i)};
      chk("ramp_b7", cap[7], e);
    end

    // input gap: random data, 3 idle cycles inside the second frame
    axi_wr(6'h00, 32'd3, 4'h1);
    rises.delete();
    lasts.delete();
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom;
      send_beat(d);
      if (b == 11) idle(3);
    end
    drain();
    chk("gap_bursts", rises.size(), 2);
    chk("gap_lasts", lasts.size(), 2);
    if (rises.size() == 2 && lasts.size() == 2) begin
      chk("gap_spacing", rises[1] - rises[0], 11);
      chk("gap_last0", lasts[0] - rises[0], 7);
      chk("gap_last1", lasts[1] - rises[1], 7);
    end

    // reset while a frame is streaming out
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 4; i++) d[32*i +: 32] = $urandom;
      send_beat(d);
    end
    chk("inflight_tvalid", m_axis_tvalid, 1'b1);
    areset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tvalid", m_axis_tvalid, 1'b0);
    chk("abort_tlast", m_axis_tlast, 1'b0);
    reset_dut();
    idle(12);
    chk("abort_quiet", m_axis_tvalid, 1'b0);
    axi_rd(6'h00, w);
    chk("abort_qout", w, 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    cyc           = 0;
    mon_on        = 1'b0;
    prev_v        = 1'b0;
    cnt_m         = 0;
    qout_m        = 0;
    areset        = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    fork
      mon_loop();
      run_all();
      begin
        #500000;
        chk("watchdog", 1'b1, 1'b0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
